// File: rtl/idct_pkg.sv
// Shared constants for the IDCT column/row datapath: beat tags, frame lengths, per-pass shifts.
// Pure declarations; no timing or backpressure of its own.
package idct_pkg;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_2PT  = 2'b01;
  localparam logic [1:0] TAG_4PT  = 2'b10;
  localparam logic [1:0] TAG_RSVD = 2'b11;

  localparam int LEN_2PT = 2;
  localparam int LEN_4PT = 4;

  localparam int SHIFT_PASS1 = 7;
  localparam int SHIFT_PASS2 = 12;

  function automatic logic tag_is_beat(input logic [1:0] tag);
    return (tag != TAG_NONE) && (tag != TAG_RSVD);
  endfunction

endpackage

// File: rtl/idct_round_clip.sv
// Per-lane round-half-up, arithmetic shift and clip to WIDTH_O; purely combinational.
// IDCT_ACC_SAT_EN selects saturation, otherwise the result wraps to its low WIDTH_O bits.
module idct_round_clip #(
  parameter int WIDTH_I = 25,
  parameter int WIDTH_O = 16,
  parameter int SHIFT   = 7
) (
  input  logic signed [WIDTH_I-1:0] i_acc,
  output logic signed [WIDTH_O-1:0] o_res
);

  localparam int WR = WIDTH_I + 1;
  localparam logic signed [WR-1:0] RND = WR'(1) << (SHIFT - 1);

  logic signed [WR-1:0] w_sum;
  logic signed [WR-1:0] w_shr;

  // One extra bit so the rounding constant cannot overflow the largest sum.
  assign w_sum = {i_acc[WIDTH_I-1], i_acc} + RND;
  assign w_shr = w_sum >>> SHIFT;

`ifdef IDCT_ACC_SAT_EN
  localparam logic signed [WR-1:0] SAT_MAX = WR'((2 ** (WIDTH_O - 1)) - 1);
  localparam logic signed [WR-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    o_res = w_shr[WIDTH_O-1:0];
    if (w_shr > SAT_MAX) begin
      o_res = SAT_MAX[WIDTH_O-1:0];
    end else if (w_shr < SAT_MIN) begin
      o_res = SAT_MIN[WIDTH_O-1:0];
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_shr[WR-1:WIDTH_O];
  assign o_res       = w_shr[WIDTH_O-1:0];
`endif

endmodule

// File: rtl/idct_col_acc.sv
// Sums 2- or 4-beat tagged product frames into four lanes; result valid one cycle after the final beat.
// Only a final beat stalls, while a result is held; IDCT_ACC_SAT_EN makes the lanes saturate instead of wrap.
module idct_col_acc
  import idct_pkg::*;
#(
  parameter int WIDTH_Y = 23,
  parameter int WIDTH_O = 16,
  parameter int SHIFT   = SHIFT_PASS1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_tag,
  input  logic signed [WIDTH_Y-1:0] y0,
  input  logic signed [WIDTH_Y-1:0] y1,
  input  logic signed [WIDTH_Y-1:0] y2,
  input  logic signed [WIDTH_Y-1:0] y3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_O-1:0] o0,
  output logic signed [WIDTH_O-1:0] o1,
  output logic signed [WIDTH_O-1:0] o2,
  output logic signed [WIDTH_O-1:0] o3,
  output logic                      frame_err
);

  localparam int WA = WIDTH_Y + 2;

  logic [1:0]                r_cnt;
  logic                      r_len2;
  logic signed [WA-1:0]      r_acc [4];
  logic                      r_out_valid;
  logic signed [WIDTH_O-1:0] r_o [4];
  logic                      r_frame_err;

  logic                      w_tag_ok;
  logic                      w_tag2;
  logic                      w_restart;
  logic [1:0]                w_cnt_eff;
  logic [1:0]                w_last_cnt;
  logic                      w_is_final;
  logic                      w_beat;
  logic                      w_mismatch;
  logic                      w_fire;
  logic signed [WIDTH_Y-1:0] w_y [4];
  logic signed [WA-1:0]      w_acc_nxt [4];
  logic signed [WIDTH_O-1:0] w_res [4];
  logic signed [WIDTH_O-1:0] w_o_nxt [4];

  assign w_y[0] = y0;
  assign w_y[1] = y1;
  assign w_y[2] = y2;
  assign w_y[3] = y3;

  assign w_tag_ok   = tag_is_beat(in_tag);
  assign w_tag2     = (in_tag == TAG_2PT);
  // A beat whose tag disagrees with the running frame is treated as the first beat of a new one.
  assign w_restart  = (r_cnt == 2'd0) || (w_tag2 != r_len2);
  assign w_cnt_eff  = w_restart ? 2'd0 : r_cnt;
  assign w_last_cnt = (in_tag == TAG_4PT) ? 2'(LEN_4PT - 1) : 2'(LEN_2PT - 1);
  assign w_is_final = w_tag_ok && (w_cnt_eff == w_last_cnt);

  // Derived from the presented tag only, never from in_valid, to keep the handshake loop-free.
  assign in_ready   = !(r_out_valid && !out_ready && w_is_final);

  assign w_beat     = in_valid && in_ready && w_tag_ok;
  assign w_mismatch = w_beat && (r_cnt != 2'd0) && (w_tag2 != r_len2);
  assign w_fire     = w_beat && w_is_final;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic                 w_mask;
    logic signed [WA-1:0] w_add;

    // Upper lanes carry no data in 2-point frames.
    assign w_mask       = w_tag2 && (i >= 2);
    assign w_add        = w_mask ? '0 : {{2{w_y[i][WIDTH_Y-1]}}, w_y[i]};
    assign w_acc_nxt[i] = (w_cnt_eff == 2'd0) ? w_add : (r_acc[i] + w_add);

    idct_round_clip #(
      .WIDTH_I (WA),
      .WIDTH_O (WIDTH_O),
      .SHIFT   (SHIFT)
    ) u_round_clip (
      .i_acc (w_acc_nxt[i]),
      .o_res (w_res[i])
    );

    assign w_o_nxt[i] = w_mask ? '0 : w_res[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 2'd0;
      r_len2      <= 1'b0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_acc[k] <= '0;
        r_o[k]   <= '0;
      end
    end else begin
      r_frame_err <= w_mismatch;

      if (w_beat) begin
        for (int k = 0; k < 4; k++) begin
          r_acc[k] <= w_acc_nxt[k];
        end
        if (w_restart) begin
          r_len2 <= w_tag2;
        end
        r_cnt <= w_fire ? 2'd0 : (w_cnt_eff + 2'd1);
      end

      if (w_fire) begin
        r_out_valid <= 1'b1;
        for (int k = 0; k < 4; k++) begin
          r_o[k] <= w_o_nxt[k];
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign o0        = r_o[0];
  assign o1        = r_o[1];
  assign o2        = r_o[2];
  assign o3        = r_o[3];
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_idct_col_acc.sv
// Scoreboard bench for idct_col_acc: expected lane results are queued per frame and checked on each output handshake.
module tb_idct_col_acc;
  import idct_pkg::*;

  localparam int WY = 23;
  localparam int WO = 16;
  localparam int SH = 7;

  typedef struct {
    longint o [4];
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           in_tag = 2'b00;
  logic signed [WY-1:0] y0 = '0;
  logic signed [WY-1:0] y1 = '0;
  logic signed [WY-1:0] y2 = '0;
  logic signed [WY-1:0] y3 = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [WO-1:0] o0, o1, o2, o3;
  logic                 frame_err;

  idct_col_acc #(
    .WIDTH_Y (WY),
    .WIDTH_O (WO),
    .SHIFT   (SH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_err = 0;
  int   last_pop = 0;
  int   prev_pop = 0;
  int   last_wait = 0;
  int   max_early_wait = 0;
  exp_t sb_q [$];
  exp_t mon_e;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint round_clip(input longint s);
    longint r;
    logic signed [WO-1:0] t;
    r = (s + (longint'(1) << (SH - 1))) >>> SH;
`ifdef IDCT_ACC_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    t = r[WO-1:0];
    r = longint'(t);
`endif
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && frame_err) n_err++;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("o0", longint'(o0), mon_e.o[0]);
        check("o1", longint'(o1), mon_e.o[1]);
        check("o2", longint'(o2), mon_e.o[2]);
        check("o3", longint'(o3), mon_e.o[3]);
        prev_pop = last_pop;
        last_pop = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Presents one beat and holds it until accepted, bounded by a cycle budget.
  task automatic beat(input logic [1:0] tag, input longint a, input longint b,
                      input longint c, input longint d, output int waits);
    in_valid = 1'b1;
    in_tag   = tag;
    y0 = a[WY-1:0];
    y1 = b[WY-1:0];
    y2 = c[WY-1:0];
    y3 = d[WY-1:0];
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_tag   = TAG_NONE;
  endtask

  task automatic frame(input logic [1:0] tag, input int nb, input longint l0, input longint l1,
                       input longint l2, input longint l3, input bit push);
    int   len;
    int   w;
    exp_t e;
    len = (tag == TAG_2PT) ? LEN_2PT : LEN_4PT;
    max_early_wait = 0;
    for (int b = 0; b < nb; b++) begin
      beat(tag, l0, l1, l2, l3, w);
      if (b == nb - 1) last_wait = w;
      else if (w > max_early_wait) max_early_wait = w;
    end
    if (nb == len) begin
      check("final_latency_vld", longint'(out_valid), 1);
      if (push) begin
        e.o[0] = round_clip(len * l0);
        e.o[1] = round_clip(len * l1);
        e.o[2] = (len == LEN_2PT) ? 0 : round_clip(len * l2);
        e.o[3] = (len == LEN_2PT) ? 0 : round_clip(len * l3);
        sb_q.push_back(e);
      end
    end
  endtask

  initial begin
    int   w;
    exp_t e;

    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    idle(1);
    check("rst_o0", longint'(o0), 0);
    check("rst_o3", longint'(o3), 0);
    check("rst_frame_err", longint'(frame_err), 0);

    // Basic 4-point frame; output must not appear before the final beat.
    for (int b = 0; b < 3; b++) beat(TAG_4PT, 64, 0, 0, 0, w);
    check("basic_early_vld", longint'(out_valid), 0);
    beat(TAG_4PT, 64, 0, 0, 0, w);
    check("basic_lat_vld", longint'(out_valid), 1);
    e.o[0] = 2; e.o[1] = 0; e.o[2] = 0; e.o[3] = 0;
    sb_q.push_back(e);
    idle(2);

    // Negative rounding in a 2-point frame; lane 2 input ignored.
    frame(TAG_2PT, 2, -64, 0, 1000, 0, 1);
    idle(2);

    // Large sums on both sides of the output range.
    frame(TAG_4PT, 4, 0, 2 ** 21, -(2 ** 21), 12345, 1);
    idle(2);

    // Tags 00 and 11 interleaved mid-frame must not disturb it.
    beat(TAG_4PT, 64, -300, 5, 7, w);
    beat(TAG_NONE, 9999, 9999, 9999, 9999, w);
    beat(TAG_RSVD, 9999, 9999, 9999, 9999, w);
    for (int b = 0; b < 3; b++) beat(TAG_4PT, 64, -300, 5, 7, w);
    e.o[0] = round_clip(256); e.o[1] = round_clip(-1200);
    e.o[2] = round_clip(20);  e.o[3] = round_clip(28);
    sb_q.push_back(e);
    idle(2);

    // Held result, then a second frame: only its final beat may stall.
    out_ready = 1'b0;
    frame(TAG_4PT, 4, 100, 200, 300, 400, 1);
    fork
      frame(TAG_4PT, 4, 10, -20, 30, -40, 1);
      begin
        repeat (8) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    idle(2);
    check("bp_early_waits", longint'(max_early_wait), 0);
    check("bp_final_stalled", longint'(last_wait > 0), 1);
    check("bp_no_gap", longint'(last_pop - prev_pop), 1);

    // Tag mismatch: partial 4-point frame abandoned by a 2-point frame.
    n_err = 0;
    frame(TAG_4PT, 2, 500, 0, 0, 0, 1);
    frame(TAG_2PT, 2, 128, 0, 0, 0, 1);
    idle(3);
    check("mismatch_err_pulses", longint'(n_err), 1);

    // Reset with a held result and a partial frame in flight.
    out_ready = 1'b0;
    frame(TAG_4PT, 4, 7, 7, 7, 7, 0);
    frame(TAG_4PT, 2, 1000, 1000, 1000, 1000, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_o1", longint'(o1), 0);
    check("midrst_o2", longint'(o2), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    frame(TAG_4PT, 4, 64, -64, 128, -128, 1);
    idle(3);

    check("scoreboard_empty", longint'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idct_col_acc.md
# idct_col_acc

Accumulating back end for the shift-add coefficient multiplier. It consumes the tagged per-coefficient product vectors (y0..y3) that the multiplier emits, one vector per cycle, and sums them over a 2-beat or 4-beat frame into four lane accumulators. It rounds, shifts and clips each sum to the residual width, then presents the four samples on a valid/ready output. It sits directly downstream of the multiplier in the IDCT column/row datapath.

## Interface
- WIDTH_Y, 23: signed width of each incoming product.
- WIDTH_O, 16: signed width of each output sample.
- SHIFT, 7: right-shift applied after rounding; legal range 1..12.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  product vector present this cycle.
- in_ready  out  1  block accepts the vector this cycle.
- in_tag  in  2  00 = none, 01 = 2-point beat, 10 = 4-point beat, 11 = reserved.
- y0, y1, y2, y3  in  WIDTH_Y each, signed  product lanes.
- out_valid  out  1  result register holds a completed frame.
- out_ready  in  1  downstream takes the result.
- o0, o1, o2, o3  out  WIDTH_O each, signed  rounded and clipped lane sums.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- A beat is accepted when in_valid && in_ready && in_tag ∈ {01,10}. Beats tagged 00 or 11 are dropped silently and do not touch state.
- Frame length is latched from the first beat's tag: 01 gives 2 beats, 10 gives 4 beats. The beat counter cnt runs 0..len-1.
- Accumulators acc0..acc3 are WIDTH_Y+2 bits wide and signed.
  - On cnt==0 the accumulators load the sign-extended y lanes.
  - On later beats they add the lanes.
  - In 2-point frames, y2 and y3 are ignored and o2/o3 are forced to 0.
- Final-beat arithmetic, per lane:
  - r = (acc_final + 2^(SHIFT-1)) >>> SHIFT, evaluated with 1 bit of headroom.
  - r is then clipped to WIDTH_O (see Configuration).
  - acc_final includes the current beat's addend.
  - The result registers load, out_valid rises, and cnt returns to 0.
- A tag mismatch mid-frame (an accepted beat whose tag differs from the latched length):
  - The partial frame is discarded and frame_err pulses.
  - The offending beat starts a new frame as its cnt==0 beat.
- Output handshake:
  - The result registers hold while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new frame completes in the same cycle. In that case the registers reload and out_valid stays 1.
- Backpressure: in_ready = !(out_valid && !out_ready && next beat is final). Non-final beats are always accepted, so there are no bubbles while the output drains.
- Reset values:
  - cnt=0, accumulators 0, latched length = 4.
  - out_valid=0, o0..o3=0, frame_err=0.
  - in_ready=1 after reset.

## Timing
- Throughput is one beat per cycle, so a 4-point frame every 4 cycles and a 2-point frame every 2 cycles.
- Latency: out_valid is asserted in the cycle after the final beat is accepted.
- Rounding and clipping sit in the same cycle as the final accumulate. That path is adder → rounder → comparator and is the critical path.
- frame_err asserts in the cycle after the mismatching beat is accepted.
- rst asserted mid-frame: the partial frame is lost and any held result is dropped. Next cycle all outputs are at reset values.
- Simultaneous final beat and out_ready on a full output register: accepted; the new result replaces the old one with no gap.

## Configuration
- IDCT_ACC_SAT_EN defined: r saturates to [-2^(WIDTH_O-1), 2^(WIDTH_O-1)-1].
- IDCT_ACC_SAT_EN undefined: r is truncated to its low WIDTH_O bits (two's-complement wrap), with no comparators.

## Structure
- Shared package idct_pkg holds:
  - Tag constants TAG_NONE=2'b00, TAG_2PT=2'b01, TAG_4PT=2'b10.
  - Frame-length constants 2 and 4.
  - Default SHIFT values for first pass (7) and second pass (12).
- Sub-module idct_round_clip (combinational, parameterised by input width, WIDTH_O, SHIFT) is instantiated four times, one per lane. It contains the `ifdef IDCT_ACC_SAT_EN` selection.

## Test plan
- Basic 4-point frame: tag 10, y0=64 on all 4 beats, other lanes 0, out_ready=1. Expect o0=2 (320>>>7), o1..o3=0, out_valid one cycle after beat 4.
- 2-point negative rounding: tag 01, y0=-64 then -64, y2=1000. Expect o0=-1, o2=0.
- Saturation: tag 10, y1=2^21 on all 4 beats. Expect o1=32767 with IDCT_ACC_SAT_EN defined, o1=0 without it.
- Backpressure: out_ready=0 with a held result, then a second 4-point frame arrives. Expect beats 1–3 accepted, in_ready=0 on beat 4 until out_ready=1, then the new result loads next cycle with no lost beat.
- Tag mismatch: tag 10 for 2 beats, then tag 01 for 2 beats (y0=128 each). Expect one frame_err pulse, then o0=2 from the 2-point frame.
- Reset mid-frame: assert rst after 2 of 4 beats. Expect out_valid=0, o*=0, then a fresh 4-beat frame produces the correct sum with no residue from the partial frame.
